// File: rtl/dispense_ctrl.sv
// Vending-machine dispense controller: per-channel stock counters, timed one-hot
// motor pulse per accepted request, and busy/done/error/empty status.
module dispense_ctrl #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 10,
    parameter int unsigned PULSE_CYC  = 3,
    parameter int unsigned SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_en,
    input  logic             i_restock,
    input  logic [SEL_W-1:0] i_sel,
    output logic [N_CH-1:0]  o_motor,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [N_CH-1:0]  o_empty
);

    localparam int unsigned CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DISP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PULSE_CYC - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_act;
    logic [STOCK_W-1:0] r_stock [N_CH];
    logic [N_CH-1:0]    r_motor;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]   w_act_nxt;
    logic [STOCK_W-1:0] w_stock_nxt [N_CH];
    logic [N_CH-1:0]    w_motor_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_sel_ok;
    logic               w_sel_empty;

    // Decode Sel against the populated channels; out-of-range values match nothing.
    always_comb begin
        w_sel_ok    = 1'b0;
        w_sel_empty = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (i_sel == SEL_W'(i)) begin
                w_sel_ok    = 1'b1;
                w_sel_empty = (r_stock[i] == '0);
            end
        end
    end

    // Next-state, stock update and registered-output next values.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_act_nxt   = r_act;
        w_err_nxt   = 1'b0;
        w_motor_nxt = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            w_stock_nxt[i] = r_stock[i];
        end

        case (r_state)
            S_IDLE: begin
                if (i_restock) begin
                    if (w_sel_ok) begin
                        for (int i = 0; i < int'(N_CH); i++) begin
                            if (i_sel == SEL_W'(i)) begin
                                w_stock_nxt[i] = STOCK_INIT;
                            end
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (i_req && i_en) begin
                    if (!w_sel_ok || w_sel_empty) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_act_nxt   = i_sel;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DISP;
                    end
                end
            end
            S_DISP: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                    for (int i = 0; i < int'(N_CH); i++) begin
                        if (r_act == SEL_W'(i) && r_stock[i] != '0) begin
                            w_stock_nxt[i] = r_stock[i] - STOCK_W'(1);
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_state_nxt == S_DISP) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                w_motor_nxt[i] = (w_act_nxt == SEL_W'(i));
            end
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_act   <= '0;
            r_motor <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                r_stock[i] <= STOCK_INIT;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_act   <= w_act_nxt;
            r_motor <= w_motor_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            for (int i = 0; i < int'(N_CH); i++) begin
                r_stock[i] <= w_stock_nxt[i];
            end
        end
    end

    // Empty flags follow the stock registers directly.
    always_comb begin
        o_empty = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            o_empty[i] = (r_stock[i] == '0);
        end
    end

    assign o_motor = r_motor;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_err   = r_err;

endmodule

// File: tb/tb_dispense_ctrl.sv
// Bench for dispense_ctrl: directed scenarios plus random traffic, checked every
// cycle against a job-timeline reference model (edge numbers, per-channel stock).
module tb_dispense_ctrl;

    localparam int N    = 4;
    localparam int P    = 3;
    localparam int INIT = 10;

    logic       clk = 1'b0;
    logic       rst, req, en, restock;
    logic [1:0] sel;
    logic [3:0] motor, empty;
    logic       busy, done, err;
    logic [2:0] motor3, empty3;
    logic       busy3, done3, err3;

    always #5 clk = ~clk;

    dispense_ctrl u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_en(en), .i_restock(restock),
        .i_sel(sel), .o_motor(motor), .o_busy(busy), .o_done(done),
        .o_err(err), .o_empty(empty)
    );

    dispense_ctrl #(.N_CH(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_en(en), .i_restock(restock),
        .i_sel(sel), .o_motor(motor3), .o_busy(busy3), .o_done(done3),
        .o_err(err3), .o_empty(empty3)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stock per channel, plus the edge at which the active job started.
    int stock [N];
    bit job;
    int t0, jch;
    int edge_no = 0;
    bit exp_err;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit q, input bit e, input bit rs, input int s);
        exp_err = 1'b0;
        if (r) begin
            job = 1'b0;
            for (int i = 0; i < N; i++) stock[i] = INIT;
        end else begin
            if (job && edge_no == t0 + P) stock[jch] = stock[jch] - 1;
            if (!job || edge_no >= t0 + P + 2) begin
                job = 1'b0;
                if (rs) begin
                    if (s < N) stock[s] = INIT;
                    else exp_err = 1'b1;
                end else if (q && e) begin
                    if (s >= N || stock[s] == 0) exp_err = 1'b1;
                    else begin
                        job = 1'b1;
                        t0  = edge_no;
                        jch = s;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit q, input bit e, input bit rs, input int s);
        int         d;
        logic [3:0] exp_motor, exp_empty;
        rst = r; req = q; en = e; restock = rs; sel = 2'(s);
        @(posedge clk);
        edge_no++;
        model_edge(r, q, e, rs, s);
        #1;
        d         = edge_no - t0;
        exp_motor = (job && d < P) ? 4'(1 << jch) : 4'd0;
        for (int i = 0; i < N; i++) exp_empty[i] = (stock[i] == 0);
        check_val("motor", 32'(motor), 32'(exp_motor));
        check_val("busy",  32'(busy),  32'(job && d <= P));
        check_val("done",  32'(done),  32'(job && d == P));
        check_val("err",   32'(err),   32'(exp_err));
        check_val("empty", 32'(empty), 32'(exp_empty));
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; en = 1'b0; restock = 1'b0; sel = 2'd0;
        job = 1'b0; t0 = 0; jch = 0;
        for (int i = 0; i < N; i++) stock[i] = INIT;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_val("rst3_busy",  32'(busy3),  32'd0);
        check_val("rst3_empty", 32'(empty3), 32'd0);

        // Single dispense on channel 2.
        step(0, 1, 1, 0, 2);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0);

        // Request without payment is ignored.
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 1);

        // Sel=3 is out of range on the three-channel instance.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 3);
        check_val("inv3_err",   32'(err3),   32'd1);
        check_val("inv3_motor", 32'(motor3), 32'd0);
        check_val("inv3_busy",  32'(busy3),  32'd0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0);

        // Drain channel 0 with a held request, then see repeated errors, then restock.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 10 * (P + 2) + 4; k++) step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Request on channel 1 during a channel-0 dispense is ignored.
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);

        // Reset during the second pulse cycle, then restock beats request.
        step(0, 1, 1, 0, 2);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 3);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(63) == 0), $urandom_range(1) == 1,
                 $urandom_range(3) != 0, $urandom_range(7) == 0,
                 int'($urandom_range(3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
